// File: rtl/command_processor.sv
// Front-end command decoder: parses header/payload words from a valid/ready
// stream, latches engine operands and issues one start pulse per command.
module command_processor #(
  parameter int COORD_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  input  logic [31:0]        cmd_data,
  output logic               cmd_ready,
  output logic               clear_start,
  input  logic               clear_done,
  output logic               raster_start,
  input  logic               raster_done,
  output logic               simd_start,
  input  logic               simd_done,
  output logic [31:0]        clear_color,
  output logic [COORD_W-1:0] v0_x,
  output logic [COORD_W-1:0] v0_y,
  output logic [COORD_W-1:0] v1_x,
  output logic [COORD_W-1:0] v1_y,
  output logic [COORD_W-1:0] v2_x,
  output logic [COORD_W-1:0] v2_y,
  output logic [7:0]         simd_op,
  output logic [31:0]        simd_arg0,
  output logic [31:0]        simd_arg1,
  output logic               busy,
  output logic               err_opcode
);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DRAIN, S_WAIT} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_CLEAR, OP_DRAW, OP_SIMD} op_t;

  state_t      state_q, state_d;
  op_t         op_q, op_d, hdr_op;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] idx_q, idx_d;
  logic        fire, err_d, xfer, start_any, done_hit;

  assign cmd_ready = (state_q != S_WAIT);
  assign busy      = (state_q != S_IDLE);
  assign xfer      = cmd_valid && cmd_ready;
  assign start_any = clear_start || raster_start || simd_start;

  always_comb begin
    case (cmd_data[31:24])
      8'h01:   hdr_op = OP_CLEAR;
      8'h02:   hdr_op = OP_DRAW;
      8'h03:   hdr_op = OP_SIMD;
      default: hdr_op = OP_NONE;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_CLEAR: done_hit = clear_done;
      OP_DRAW:  done_hit = raster_done;
      OP_SIMD:  done_hit = simd_done;
      default:  done_hit = 1'b0;
    endcase
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    fire    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: if (xfer) begin
        if (hdr_op == OP_NONE) begin
          err_d = 1'b1;
          if (cmd_data[15:0] != 16'd0) begin
            cnt_d   = cmd_data[15:0];
            state_d = S_DRAIN;
          end
        end else begin
          op_d  = hdr_op;
          idx_d = 16'd0;
          if (cmd_data[15:0] == 16'd0) begin
            fire    = 1'b1;
            state_d = S_WAIT;
          end else begin
            cnt_d   = cmd_data[15:0];
            state_d = S_RECV;
          end
        end
      end
      S_RECV: if (xfer) begin
        cnt_d = cnt_q - 16'd1;
        idx_d = idx_q + 16'd1;
        if (cnt_q == 16'd1) begin
          fire    = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_DRAIN: if (xfer) begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) state_d = S_IDLE;
      end
      S_WAIT: begin
        // Done is ignored while our own start pulse is still on the wire.
        if (!start_any && done_hit) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= OP_NONE;
      cnt_q        <= '0;
      idx_q        <= '0;
      clear_start  <= 1'b0;
      raster_start <= 1'b0;
      simd_start   <= 1'b0;
      err_opcode   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      clear_start  <= fire && (op_d == OP_CLEAR);
      raster_start <= fire && (op_d == OP_DRAW);
      simd_start   <= fire && (op_d == OP_SIMD);
      err_opcode   <= err_d;
    end
  end

  // NOTE: operand registers are reset because an aborted command must leave
  // them zeroed, not holding a partial payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clear_color <= '0;
      v0_x        <= '0;
      v0_y        <= '0;
      v1_x        <= '0;
      v1_y        <= '0;
      v2_x        <= '0;
      v2_y        <= '0;
      simd_op     <= '0;
      simd_arg0   <= '0;
      simd_arg1   <= '0;
    end else if (xfer) begin
      if (state_q == S_IDLE && hdr_op == OP_SIMD) simd_op <= cmd_data[23:16];
      if (state_q == S_RECV) begin
        case (op_q)
          OP_CLEAR: if (idx_q == 16'd0) clear_color <= cmd_data;
          OP_DRAW: begin
            case (idx_q)
              16'd0:   v0_x <= cmd_data[COORD_W-1:0];
              16'd1:   v0_y <= cmd_data[COORD_W-1:0];
              16'd2:   v1_x <= cmd_data[COORD_W-1:0];
              16'd3:   v1_y <= cmd_data[COORD_W-1:0];
              16'd4:   v2_x <= cmd_data[COORD_W-1:0];
              16'd5:   v2_y <= cmd_data[COORD_W-1:0];
              default: ;
            endcase
          end
          OP_SIMD: begin
            if (idx_q == 16'd0) simd_arg0 <= cmd_data;
            if (idx_q == 16'd1) simd_arg1 <= cmd_data;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_command_processor.sv
// Scoreboard bench for command_processor: expected start/error events with
// operand snapshots are queued at the accept edge and checked when they appear.
module tb_command_processor;

  localparam int COORD_W = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cmd_valid;
  logic [31:0]        cmd_data;
  logic               cmd_ready;
  logic               clear_start, raster_start, simd_start;
  logic               clear_done, raster_done, simd_done;
  logic [31:0]        clear_color;
  logic [COORD_W-1:0] v0_x, v0_y, v1_x, v1_y, v2_x, v2_y;
  logic [7:0]         simd_op;
  logic [31:0]        simd_arg0, simd_arg1;
  logic               busy, err_opcode;

  command_processor #(.COORD_W(COORD_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .clear_start(clear_start), .clear_done(clear_done),
    .raster_start(raster_start), .raster_done(raster_done),
    .simd_start(simd_start), .simd_done(simd_done), .clear_color(clear_color),
    .v0_x(v0_x), .v0_y(v0_y), .v1_x(v1_x), .v1_y(v1_y), .v2_x(v2_x), .v2_y(v2_y),
    .simd_op(simd_op), .simd_arg0(simd_arg0), .simd_arg1(simd_arg1),
    .busy(busy), .err_opcode(err_opcode)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_CLEAR, EV_RASTER, EV_SIMD, EV_ERR} ev_t;
  typedef struct {
    ev_t                     kind;
    int                      cyc;
    logic [31:0]             color;
    logic [5:0][COORD_W-1:0] v;
    logic [7:0]              op;
    logic [31:0]             a0, a1;
  } ev_s;

  ev_s sb[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;

  // Reference operand state, updated from the stimulus as it is sent.
  logic [31:0]             m_color;
  logic [5:0][COORD_W-1:0] m_v;
  logic [7:0]              m_op;
  logic [31:0]             m_a0, m_a1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0][COORD_W-1:0] dut_v();
    return {v2_y, v2_x, v1_y, v1_x, v0_y, v0_x};
  endfunction

  task automatic model_zero();
    m_color = '0; m_v = '0; m_op = '0; m_a0 = '0; m_a1 = '0;
  endtask

  // Event monitor: every start/err pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n) begin
      int  n;
      ev_t got;
      ev_s e;
      n = int'(clear_start) + int'(raster_start) + int'(simd_start) + int'(err_opcode);
      if (n > 0) begin
        vectors++;
        got = clear_start ? EV_CLEAR : raster_start ? EV_RASTER : simd_start ? EV_SIMD : EV_ERR;
        if (n > 1 || sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_pulse: got %0d pulses kind %0d, expected events queued %0d", n, got, sb.size());
        end else begin
          e = sb.pop_front();
          if (got !== e.kind || cyc !== e.cyc) begin
            miscompares++;
            $display("FAIL event: got kind %0d cycle %0d, expected kind %0d cycle %0d", got, cyc, e.kind, e.cyc);
          end
          if (clear_color !== e.color || dut_v() !== e.v || simd_op !== e.op ||
              simd_arg0 !== e.a0 || simd_arg1 !== e.a1) begin
            miscompares++;
            $display("FAIL operands: got color %h v %h op %h a0 %h a1 %h, expected color %h v %h op %h a0 %h a1 %h",
                     clear_color, dut_v(), simd_op, simd_arg0, simd_arg1, e.color, e.v, e.op, e.a0, e.a1);
          end
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input int gap, input logic push, input ev_t kind);
    int  t;
    ev_s e;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = d;
    t = 0;
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: got cmd_ready 0 for %0d cycles, expected 1", t);
    end
    @(posedge clk);
    if (push) begin
      e.kind = kind; e.cyc = cyc + 1; e.color = m_color; e.v = m_v;
      e.op = m_op; e.a0 = m_a0; e.a1 = m_a1;
      sb.push_back(e);
    end
    #1;
    cmd_valid = 1'b0;
    cmd_data  = $urandom;
  endtask

  task automatic send_cmd(input logic [31:0] hdr, input logic [31:0] w[8], input int n, input int gap);
    logic [7:0] opc;
    logic       known;
    ev_t        kind;
    opc   = hdr[31:24];
    known = (opc >= 8'h01 && opc <= 8'h03);
    kind  = (opc == 8'h01) ? EV_CLEAR : (opc == 8'h02) ? EV_RASTER : (opc == 8'h03) ? EV_SIMD : EV_ERR;
    if (opc == 8'h03) m_op = hdr[23:16];
    send_word(hdr, 0, !known || (n == 0), kind);
    for (int i = 0; i < n; i++) begin
      if (opc == 8'h01 && i == 0) m_color = w[i];
      if (opc == 8'h02 && i < 6)  m_v[i] = w[i][COORD_W-1:0];
      if (opc == 8'h03 && i == 0) m_a0 = w[i];
      if (opc == 8'h03 && i == 1) m_a1 = w[i];
      send_word(w[i], gap, known && (i == n - 1), kind);
    end
  endtask

  // Called just after the final accept edge: hold in WAIT, then release with done.
  task automatic finish_cmd(input ev_t kind, input logic wrong_done);
    vectors++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_state: got ready %b busy %b, expected ready 0 busy 1", cmd_ready, busy);
    end
    repeat (2) @(negedge clk);
    if (wrong_done) begin
      clear_done  = (kind != EV_CLEAR);
      raster_done = (kind != EV_RASTER);
      simd_done   = (kind != EV_SIMD);
      @(negedge clk);
      {clear_done, raster_done, simd_done} = '0;
      vectors++;
      if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL foreign_done: got ready %b busy %b, expected ready 0 busy 1", cmd_ready, busy);
      end
    end
    clear_done  = (kind == EV_CLEAR);
    raster_done = (kind == EV_RASTER);
    simd_done   = (kind == EV_SIMD);
    @(negedge clk);
    {clear_done, raster_done, simd_done} = '0;
    vectors++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL release: got ready %b busy %b, expected ready 1 busy 0", cmd_ready, busy);
    end
  endtask

  task automatic check_drained(input string name);
    repeat (3) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_pending: got %0d outstanding events, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_zero();
    @(negedge clk);
    vectors++;
    if ({busy, cmd_ready, clear_start, raster_start, simd_start, err_opcode} !== 6'b010000 ||
        clear_color !== '0 || dut_v() !== '0 || simd_op !== '0 || simd_arg0 !== '0 || simd_arg1 !== '0) begin
      miscompares++;
      $display("FAIL reset: got busy %b ready %b starts %b%b%b err %b color %h v %h, expected idle and zero",
               busy, cmd_ready, clear_start, raster_start, simd_start, err_opcode, clear_color, dut_v());
    end
  endtask

  task automatic test_clear();
    logic [31:0] w[8] = '{default: 0};
    send_cmd(32'h0100_0000, w, 0, 0);
    finish_cmd(EV_CLEAR, 1'b0);
    check_drained("clear");
  endtask

  task automatic test_draw_gaps();
    logic [31:0] w[8] = '{10, 10, 50, 10, 30, 40, 0, 0};
    send_cmd(32'h0200_0006, w, 6, 2);
    finish_cmd(EV_RASTER, 1'b0);
    check_drained("draw");
  endtask

  task automatic test_simd();
    logic [31:0] w[8] = '{32'hDEAD_BEEF, 32'h1, 0, 0, 0, 0, 0, 0};
    send_cmd(32'h0305_0002, w, 2, 0);
    finish_cmd(EV_SIMD, 1'b1);
    check_drained("simd");
  endtask

  task automatic test_unknown();
    logic [31:0] w[8] = '{32'h1111, 32'h2222, 32'h3333, 0, 0, 0, 0, 0};
    logic [31:0] c[8] = '{32'h1234_5678, 0, 0, 0, 0, 0, 0, 0};
    send_cmd(32'h7F00_0003, w, 3, 1);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_idle: got busy %b ready %b, expected busy 0 ready 1", busy, cmd_ready);
    end
    send_cmd(32'h0100_0001, c, 1, 0);
    finish_cmd(EV_CLEAR, 1'b0);
    check_drained("unknown");
  endtask

  task automatic test_long_draw();
    logic [31:0] w[8] = '{32'hA001, 32'hA002, 32'hA003, 32'hA004, 32'hA005, 32'hA006, 32'hBEEF, 32'hCAFE};
    send_cmd(32'h0200_0008, w, 8, 0);
    finish_cmd(EV_RASTER, 1'b0);
    check_drained("long_draw");
  endtask

  task automatic test_reset_mid();
    logic [31:0] w[8] = '{5, 6, 7, 8, 9, 10, 0, 0};
    send_word(32'h0200_0006, 0, 1'b0, EV_RASTER);
    for (int i = 0; i < 3; i++) send_word(w[i], 0, 1'b0, EV_RASTER);
    @(negedge clk);
    rst_n = 1'b0;
    model_zero();
    #1;
    vectors++;
    if (busy !== 1'b0 || dut_v() !== '0 || raster_start !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got busy %b v %h raster_start %b, expected 0 0 0", busy, dut_v(), raster_start);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_drained("reset_mid");
    send_cmd(32'h0200_0006, w, 6, 0);
    finish_cmd(EV_RASTER, 1'b0);
    check_drained("after_reset");
  endtask

  initial begin
    cmd_valid = 1'b0;
    cmd_data  = '0;
    {clear_done, raster_done, simd_done} = '0;
    test_reset();
    test_clear();
    test_draw_gaps();
    test_simd();
    test_unknown();
    test_long_draw();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
